seq_gen: RTL and testbench

//   Serial bit-pattern transmitter, the generator counterpart of the 1101 sequence detector.
//   - Captures a pattern of up to PAT_W bits, a length, a repeat count and an inter-repeat gap.
//   - Shifts the pattern out MSB-first, one bit per clock, with a valid qualifier.
//   - Drives detector stimulus and serial test links; data_out connects directly to a detector data_in.

---
 rtl/seq_gen.sv | 171 +++++++++++++++++
 tb/tb_seq_gen.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// ============================================================================
// Module   : seq_gen
// Brief    : Serial bit-pattern transmitter, MSB-first with valid/first/done.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 3,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len_m1,
    input  logic [CNT_W-1:0] repeat_m1,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             ready,
    output logic             data_out,
    output logic             data_valid,
    output logic             first_bit,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PAT_W-1:0]   r_pat, w_pat_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [CNT_W-1:0]   r_rep, w_rep_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [LEN_W-1:0]   r_bit_idx, w_bit_idx_nxt;
    logic [CNT_W-1:0]   r_rep_cnt, w_rep_cnt_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic               r_data_out, w_data_out_nxt;
    logic               r_data_valid, w_data_valid_nxt;
    logic               r_first_bit, w_first_bit_nxt;
    logic               r_done, w_done_nxt;
    logic               r_ready, w_ready_nxt;
    logic [LEN_W-1:0]   w_bit_dec;

    assign w_bit_dec = r_bit_idx - LEN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pat        <= '0;
            r_len        <= '0;
            r_rep        <= '0;
            r_gap        <= '0;
            r_bit_idx    <= '0;
            r_rep_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_first_bit  <= 1'b0;
            r_done       <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_pat        <= w_pat_nxt;
            r_len        <= w_len_nxt;
            r_rep        <= w_rep_nxt;
            r_gap        <= w_gap_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_rep_cnt    <= w_rep_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_first_bit  <= w_first_bit_nxt;
            r_done       <= w_done_nxt;
            r_ready      <= w_ready_nxt;
        end
    end

    // Outputs are computed for the state being entered so they can be registered.
    always_comb begin
        w_state_nxt      = r_state;
        w_pat_nxt        = r_pat;
        w_len_nxt        = r_len;
        w_rep_nxt        = r_rep;
        w_gap_nxt        = r_gap;
        w_bit_idx_nxt    = r_bit_idx;
        w_rep_cnt_nxt    = r_rep_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_data_out_nxt   = 1'b0;
        w_data_valid_nxt = 1'b0;
        w_first_bit_nxt  = 1'b0;
        w_done_nxt       = 1'b0;
        w_ready_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
                if (start) begin
                    w_pat_nxt        = pattern;
                    w_len_nxt        = len_m1;
                    w_rep_nxt        = repeat_m1;
                    w_gap_nxt        = gap_len;
                    w_bit_idx_nxt    = len_m1;
                    w_rep_cnt_nxt    = '0;
                    w_state_nxt      = S_SEND;
                    w_ready_nxt      = 1'b0;
                    w_data_valid_nxt = 1'b1;
                    w_data_out_nxt   = pattern[len_m1];
                    w_first_bit_nxt  = 1'b1;
                end
            end
            S_SEND: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                end else if (r_bit_idx != '0) begin
                    w_bit_idx_nxt    = w_bit_dec;
                    w_data_valid_nxt = 1'b1;
                    w_data_out_nxt   = r_pat[w_bit_dec];
                end else if (r_rep_cnt == r_rep) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_rep_cnt_nxt = r_rep_cnt + CNT_W'(1);
                    if (r_gap == '0) begin
                        w_bit_idx_nxt    = r_len;
                        w_data_valid_nxt = 1'b1;
                        w_data_out_nxt   = r_pat[r_len];
                        w_first_bit_nxt  = 1'b1;
                    end else begin
                        w_gap_cnt_nxt = r_gap;
                        w_state_nxt   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                end else if (r_gap_cnt == GAP_W'(1)) begin
                    w_state_nxt      = S_SEND;
                    w_bit_idx_nxt    = r_len;
                    w_data_valid_nxt = 1'b1;
                    w_data_out_nxt   = r_pat[r_len];
                    w_first_bit_nxt  = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    assign ready      = r_ready;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign first_bit  = r_first_bit;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_gen.sv
// ============================================================================
// Module   : tb_seq_gen
// Brief    : Randomized self-checking bench for seq_gen against a stream model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] pattern;
    logic [2:0] len_m1;
    logic [7:0] repeat_m1;
    logic [3:0] gap_len;
    logic       abort;
    logic       ready;
    logic       data_out;
    logic       data_valid;
    logic       first_bit;
    logic       done;

    logic [4:0] obs;
    logic [4:0] exp_q[$];
    int         checks;
    int         failures;

    assign obs = {ready, done, first_bit, data_valid, data_out};

    seq_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pattern    (pattern),
        .len_m1     (len_m1),
        .repeat_m1  (repeat_m1),
        .gap_len    (gap_len),
        .abort      (abort),
        .ready      (ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .first_bit  (first_bit),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle {ready,done,first,valid,dout} from the first bit through done.
    task automatic build_exp(input logic [7:0] p, input int len, input int rep, input int gap);
        exp_q.delete();
        for (int r = 0; r <= rep; r++) begin
            for (int b = len; b >= 0; b--)
                exp_q.push_back({1'b0, 1'b0, (b == len), 1'b1, p[b]});
            if (r < rep)
                for (int g = 0; g < gap; g++) exp_q.push_back(5'b00000);
        end
        exp_q.push_back(5'b11000);
    endtask

    task automatic launch(input logic [7:0] p, input int len, input int rep, input int gap);
        pattern   = p;
        len_m1    = 3'(len);
        repeat_m1 = 8'(rep);
        gap_len   = 4'(gap);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        pattern   = 8'($urandom);
        len_m1    = 3'($urandom);
        repeat_m1 = 8'($urandom);
        gap_len   = 4'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (obs !== 5'b10000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", obs, 5'b10000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== 5'b10000) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=%b", obs, 5'b10000);
        end
    endtask

    task automatic test_basic();
        build_exp(8'h0D, 3, 0, 0);
        launch(8'h0D, 3, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL basic cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_detector();
        logic [3:0] win;
        int         flags;
        int         nbits;
        win = '0; flags = 0; nbits = 0;
        build_exp(8'h0D, 3, 2, 0);
        launch(8'h0D, 3, 2, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL detector_stream cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            if (data_valid) begin
                win = {win[2:0], data_out};
                nbits++;
                if (nbits >= 4 && win == 4'b1101) flags++;
            end
            tick();
        end
        checks++;
        if (flags != 3 || nbits != 12) begin
            failures++;
            $display("FAIL detector_flags got=%0d/%0d exp=3/12", flags, nbits);
        end
    endtask

    task automatic test_gap();
        build_exp(8'h0D, 3, 1, 2);
        launch(8'h0D, 3, 1, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL gap cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            logic [7:0] p;
            int         len, rep, gap, nvalid;
            p = 8'($urandom); len = $urandom_range(0, 7);
            rep = $urandom_range(0, 3); gap = $urandom_range(0, 3);
            nvalid = 0;
            build_exp(p, len, rep, gap);
            launch(p, len, rep, gap);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random t=%0d cyc=%0d got=%b exp=%b", t, i, obs, exp_q[i]);
                end
                if (data_valid) nvalid++;
                tick();
            end
            checks++;
            if (nvalid != (len + 1) * (rep + 1)) begin
                failures++;
                $display("FAIL random_count t=%0d got=%0d exp=%0d", t, nvalid, (len + 1) * (rep + 1));
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_abort();
        build_exp(8'h0D, 3, 0, 0);
        launch(8'h0D, 3, 0, 0);
        tick();
        checks++;
        if (obs !== exp_q[1]) begin
            failures++;
            $display("FAIL abort_second_bit got=%b exp=%b", obs, exp_q[1]);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (obs !== 5'b10000) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=%b", obs, 5'b10000);
        end
        tick();
        checks++;
        if (obs !== 5'b10000) begin
            failures++;
            $display("FAIL abort_no_done got=%b exp=%b", obs, 5'b10000);
        end
        // Abort during a gap, then start+abort together from IDLE.
        build_exp(8'hA5, 1, 2, 3);
        launch(8'hA5, 1, 2, 3);
        for (int i = 0; i < 3; i++) tick();
        abort = 1'b1;
        tick();
        checks++;
        if (obs !== 5'b10000) begin
            failures++;
            $display("FAIL abort_gap got=%b exp=%b", obs, 5'b10000);
        end
        build_exp(8'h96, 4, 1, 1);
        launch(8'h96, 4, 1, 1);
        abort = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_restart cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        build_exp(8'h0D, 3, 0, 0);
        launch(8'h0D, 3, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL ignored_start cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            if (i == 1) begin
                pattern = 8'hF0; len_m1 = 3'd7; start = 1'b1;
                tick();
                start = 1'b0;
            end else if (i < exp_q.size() - 1) begin
                tick();
            end
        end
        build_exp(8'h3C, 5, 1, 0);
        launch(8'h3C, 5, 1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_in_gap();
        launch(8'h0D, 3, 1, 3);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL in_gap got=%b exp=%b", obs, 5'b00000);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b10000) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", obs, 5'b10000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== 5'b10000) begin
            failures++;
            $display("FAIL no_resume got=%b exp=%b", obs, 5'b10000);
        end
        build_exp(8'h01, 0, 3, 0);
        launch(8'h01, 0, 3, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL one_bit cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_maxima();
        logic [7:0] p;
        p = 8'($urandom);
        build_exp(p, 7, 255, 15);
        launch(p, 7, 255, 15);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL maxima cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            tick();
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        start = 1'b0; abort = 1'b0;
        pattern = '0; len_m1 = '0; repeat_m1 = '0; gap_len = '0;
        test_reset();
        test_basic();
        test_detector();
        test_gap();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_in_gap();
        test_maxima();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
